// File: rtl/register_file_mp.sv
// rtl/register_file_mp.sv - multi-ported register file with write bypass and busy scoreboard
//
// Purpose: register bank for decode/writeback. It has NUM_READ combinational read ports,
// two write ports (0 = ALU, 1 = memory, port 1 wins on a collision) and same-cycle
// write-to-read bypass. It can hardwire register 0 to zero, and it keeps one busy bit
// per register so decode can stall on hazards.
//
// Ports:
//   clk, reset             rising-edge clock, synchronous active-high reset
//   rd_addr / rd_data      packed read address / data, port k at [k*W +: W]
//   rd_busy                scoreboard bit of each read address (clear-bypassed)
//   we0/waddr0/wdata0      write port 0 (ALU)
//   we1/waddr1/wdata1      write port 1 (memory)
//   set_busy/busy_addr     mark a register as having an outstanding producer
//   any_busy               OR of all scoreboard bits
module register_file_mp #(
  parameter int REGISTER_SIZE = 32,
  parameter int ADDRESS_SIZE  = 5,
  parameter int NUM_READ      = 2,
  parameter bit ZERO_REG      = 1'b1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_READ*ADDRESS_SIZE-1:0]  rd_addr,
  output logic [NUM_READ*REGISTER_SIZE-1:0] rd_data,
  output logic [NUM_READ-1:0]               rd_busy,
  input  logic                              we0,
  input  logic [ADDRESS_SIZE-1:0]           waddr0,
  input  logic [REGISTER_SIZE-1:0]          wdata0,
  input  logic                              we1,
  input  logic [ADDRESS_SIZE-1:0]           waddr1,
  input  logic [REGISTER_SIZE-1:0]          wdata1,
  input  logic                              set_busy,
  input  logic [ADDRESS_SIZE-1:0]           busy_addr,
  output logic                              any_busy
);

  localparam int DEPTH = 1 << ADDRESS_SIZE;

  logic [REGISTER_SIZE-1:0] regs [DEPTH];
  logic [DEPTH-1:0]         busy;

  // One-hot decode of each write port and the busy-set request. The zero register is
  // removed here, so a write or set to it never reaches storage or the scoreboard.
  logic [DEPTH-1:0] hit0;
  logic [DEPTH-1:0] hit1;
  logic [DEPTH-1:0] set_hit;

  always_comb begin
    hit0    = '0;
    hit1    = '0;
    set_hit = '0;
    for (int r = 0; r < DEPTH; r++) begin
      hit0[r]    = we0 && (waddr0 == ADDRESS_SIZE'(r));
      hit1[r]    = we1 && (waddr1 == ADDRESS_SIZE'(r));
      set_hit[r] = set_busy && (busy_addr == ADDRESS_SIZE'(r));
    end
    if (ZERO_REG) begin
      hit0[0]    = 1'b0;
      hit1[0]    = 1'b0;
      set_hit[0] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < DEPTH; r++) begin
        regs[r] <= '0;
      end
      busy <= '0;
    end else begin
      for (int r = 0; r < DEPTH; r++) begin
        if (hit1[r]) begin
          regs[r] <= wdata1;
        end else if (hit0[r]) begin
          regs[r] <= wdata0;
        end
      end
      // A new producer issued in the same cycle as a writeback keeps the register busy.
      busy <= (busy & ~(hit0 | hit1)) | set_hit;
    end
  end

  for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
    logic [ADDRESS_SIZE-1:0]  addr;
    logic [REGISTER_SIZE-1:0] data;

    assign addr = rd_addr[k*ADDRESS_SIZE +: ADDRESS_SIZE];

    always_comb begin
      data = regs[addr];
      if (hit1[addr]) begin
        data = wdata1;
      end else if (hit0[addr]) begin
        data = wdata0;
      end
      if (reset || (ZERO_REG && (addr == '0))) begin
        data = '0;
      end
    end

    assign rd_data[k*REGISTER_SIZE +: REGISTER_SIZE] = data;
    // A writeback presented this cycle already releases the consumer.
    assign rd_busy[k] = !reset && busy[addr] && !(hit0[addr] || hit1[addr]);
  end

  assign any_busy = !reset && (|busy);

endmodule
